seq_detect_param: RTL
=====================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PATTERN_W, default 4, meaning pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter PATTERN, default 4'b0011, meaning target bit pattern, PATTERN_W bits wide, MSB received first.
REQ-003 SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping detection, 0 = non-overlapping.
REQ-004 SHALL have parameter COUNT_W, default 8, meaning match counter width.
REQ-005 SHALL derive localparam SW = clog2(PATTERN_W+1) as the state width.
REQ-006 clk  input  1  system clock; all state changes on the rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 x  input  1  serial data bit.
REQ-009 en  input  1  advance enable; the bit on x is consumed only when en=1.
REQ-010 y  output  1  detect flag, Moore, high while cs == PATTERN_W.
REQ-011 cs  output  SW  current state = number of pattern bits currently matched.
REQ-012 ns  output  SW  next state, combinational from cs and x.
REQ-013 match_count  output  COUNT_W  number of detections since reset.

Function
REQ-014 SHALL encode state k (0..PATTERN_W) as "the first k bits of PATTERN matched"; state PATTERN_W is DETECT.
REQ-015 SHALL compute ns for cs=k<PATTERN_W: k+1 if x == PATTERN[PATTERN_W-1-k], else the longest proper prefix of PATTERN that is a suffix of the received bits (prefix-function fallback), resolved at elaboration time.
REQ-016 SHALL compute ns from DETECT with OVERLAP=1 as the transition from the failure state of the full pattern on x.
REQ-017 SHALL compute ns from DETECT with OVERLAP=0 as the transition from state 0 on x.
REQ-018 SHALL load cs <= ns on the rising edge when en=1 and rst=0, and SHALL hold cs when en=0.
REQ-019 SHALL drive ns combinationally regardless of en.
REQ-020 SHALL derive y from cs only (no x path), so y rises one cycle after the edge that consumes the last pattern bit and lasts one enabled cycle, or longer if en is held low.
REQ-021 SHALL increment match_count on every edge where en=1 and ns == PATTERN_W, so DETECT re-entered on consecutive cycles counts each entry.
REQ-022 SHALL saturate match_count at all-ones with no wrap-around.
REQ-023 SHALL never drive cs outside 0..PATTERN_W, and SHALL force ns to 0 for any unreachable cs encoding.

Reset
REQ-024 SHALL on a rising edge with rst=1 set cs=0 and match_count=0; outputs SHALL follow as y=0 and ns=transition from state 0 on x.
REQ-025 SHALL give rst priority over en, including reset asserted mid-pattern or while in DETECT.
REQ-026 SHALL leave cs and match_count undefined before the first reset edge.

Configuration
REQ-027 SHALL compile match_count logic only when SEQ_DETECT_COUNT_EN is defined.
REQ-028 SHALL keep the match_count port without SEQ_DETECT_COUNT_EN, drive it constant 0, and contain no counter flops.

Verification
REQ-029 Defaults, rst 1 cycle, en=1, x=0,0,1,1,0,0,1,1 then 0s -> cs 1,2,3,4,1,2,3,4,... y high in cycles 5 and 9 only, match_count=2.
REQ-030 PATTERN_W=3, PATTERN=3'b101, OVERLAP=1, x=1,0,1,0,1 -> y high after bits 3 and 5, match_count=2.
REQ-031 Same stimulus with OVERLAP=0 -> y high after bit 3 only, match_count=1.
REQ-032 Defaults, x=0,0,1 then en=0 for 3 cycles, then x=1 with en=1 -> cs held at 3 while en=0, then y=1, count=1.
REQ-033 Defaults, rst pulsed in state 3 -> cs=0 on that edge; the following 0011 gives a single detection.
REQ-034 COUNT_W=2 with SEQ_DETECT_COUNT_EN, 5 detections -> match_count saturates at 3; without the macro, match_count stays 0.

Source files
------------

// File: rtl/seq_detect_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_detect_param : serial bit-pattern detector, prefix-function Moore FSM. |
// | Optional saturating match counter enabled by SEQ_DETECT_COUNT_EN.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seq_detect_param #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b0011,
  parameter int                   OVERLAP   = 1,
  parameter int                   COUNT_W   = 8,
  localparam int                  SW        = $clog2(PATTERN_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               en,
  output logic               y,
  output logic [SW-1:0]      cs,
  output logic [SW-1:0]      ns,
  output logic [COUNT_W-1:0] match_count
);

  localparam logic [SW-1:0] DETECT = SW'(PATTERN_W);

  // Next state for "k pattern bits matched, then b arrives": the longest pattern
  // prefix that is a suffix of the received string. Leaving DETECT without
  // overlap restarts from an empty history.
  function automatic int calc_next(input int k, input logic b);
    logic [PATTERN_W:0] s;
    int                 best;
    logic               ok;
    s    = '0;
    best = 0;
    if (k == PATTERN_W && OVERLAP == 0) begin
      best = (b == PATTERN[PATTERN_W-1]) ? 1 : 0;
    end else begin
      for (int i = 0; i < PATTERN_W; i++) begin
        if (i < k) s[i] = PATTERN[PATTERN_W-1-i];
      end
      s[k] = b;
      for (int j = 1; j <= PATTERN_W; j++) begin
        if (j <= k + 1) begin
          ok = 1'b1;
          for (int i = 0; i < j; i++) begin
            if (s[k+1-j+i] != PATTERN[PATTERN_W-1-i]) ok = 1'b0;
          end
          if (ok) best = j;
        end
      end
    end
    return best;
  endfunction

  logic [SW-1:0] next_on0 [0:PATTERN_W];
  logic [SW-1:0] next_on1 [0:PATTERN_W];
  logic [SW-1:0] cs_q;
  logic [SW-1:0] ns_d;

  for (genvar k = 0; k <= PATTERN_W; k++) begin : g_tbl
    localparam int NS0 = calc_next(k, 1'b0);
    localparam int NS1 = calc_next(k, 1'b1);
    assign next_on0[k] = SW'(NS0);
    assign next_on1[k] = SW'(NS1);
  end

  always_comb begin
    ns_d = '0;
    if (cs_q <= DETECT) begin
      ns_d = x ? next_on1[cs_q] : next_on0[cs_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q <= '0;
    end else if (en) begin
      cs_q <= ns_d;
    end
  end

  assign cs = cs_q;
  assign ns = ns_d;
  assign y  = (cs_q == DETECT);

`ifdef SEQ_DETECT_COUNT_EN
  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (en && (ns_d == DETECT) && (count_q != {COUNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign match_count = count_q;
`else
  assign match_count = {COUNT_W{1'b0}};
`endif

endmodule
`default_nettype wire
